// File: rtl/axis_route_pkg.sv
// Shared constants and types for the route-select stage in front of the 1x2 switch.
package axis_route_pkg;

  localparam logic [1:0] ROUTE_NONE = 2'b00;
  localparam logic [1:0] ROUTE_M0   = 2'b01;
  localparam logic [1:0] ROUTE_M1   = 2'b10;
  localparam logic [1:0] ROUTE_BOTH = 2'b11;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    PASS     = 1'b1
  } state_t;

  // Stored beat: data + user + last + strb + keep + id + dest + 2-bit route tag
  function automatic int payload_w(input int dataw);
    return dataw + 1 + 1 + (dataw / 8) + (dataw / 8) + 1 + 1 + 2;
  endfunction

endpackage

// File: rtl/axis_route_sel_sync_if.sv
// AXI-Stream bundle used on both sides of the route-select stage.
// Handshake: a beat transfers on a clock edge where tvalid and tready are both
// high; the master holds tvalid and all payload fields stable until that edge,
// and tvalid never depends combinationally on tready.
interface axis_route_sel_sync_if #(
  parameter int DATAW = 24
);
  localparam int KW = DATAW / 8;

  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tuser;
  logic             tlast;
  logic [KW-1:0]    tstrb;
  logic [KW-1:0]    tkeep;
  logic             tid;
  logic             tdest;

  modport master (
    output tdata, tvalid, tuser, tlast, tstrb, tkeep, tid, tdest,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast, tstrb, tkeep, tid, tdest,
    output tready
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Generic 2-entry register slice over a flat payload vector.
// in_ready_o is registered and means "not full"; output is a registered head.
module axis_skid_buf #(
  parameter int PW = 8
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_data_o
);

  logic [PW-1:0] mem_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          ready_q;
  logic          push;
  logic          pop;

  assign push = in_valid_i & ready_q;
  assign pop  = (count_q != 2'd0) & out_ready_i;

  // Occupancy next-state; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers, occupancy and the registered not-full flag
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_route_sel_sync.sv
// Route-select stage: tags each beat with a route that only changes at SOF,
// drops pre-sync and unrouted beats, and drives the switch enables per beat.
module axis_route_sel_sync
  import axis_route_pkg::*;
#(
  parameter int DATAW = 24,
  parameter int CNTW  = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [1:0]               route_req,
  output logic [1:0]               route_cur,
  output logic                     route_pend,
  axis_route_sel_sync_if.slave     s_axis,
  axis_route_sel_sync_if.master    m_axis,
  output logic                     m0_en,
  output logic                     m1_en,
  output logic [CNTW-1:0]          frame_cnt,
  output logic [CNTW-1:0]          drop_cnt,
  output logic                     state_dbg
);

  localparam int KW = DATAW / 8;
  localparam int PW = payload_w(DATAW);

  state_t          state_q, state_d;
  logic [1:0]      route_cur_q, route_cur_d;
  logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  logic            buf_in_ready;
  logic            buf_out_valid;
  logic [PW-1:0]   in_pl;
  logic [PW-1:0]   out_pl;
  logic [1:0]      out_tag;
  logic            accept;
  logic            sof;
  logic            wr;
  logic [1:0]      eff_route;

  assign accept    = s_axis.tvalid & buf_in_ready;
  assign sof       = s_axis.tuser;
  // An SOF beat is tagged with the route sampled in its own cycle
  assign eff_route = (accept & sof) ? route_req : route_cur_q;
  assign in_pl     = {eff_route, s_axis.tdest, s_axis.tid, s_axis.tkeep,
                      s_axis.tstrb, s_axis.tlast, s_axis.tuser, s_axis.tdata};

  // Write decision plus route/state/counter next-state
  always_comb begin
    wr          = accept & ((state_q == PASS) | sof) & (eff_route != ROUTE_NONE);
    state_d     = state_q;
    route_cur_d = route_cur_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (accept & sof) begin
      state_d     = PASS;
      route_cur_d = route_req;
    end
    if (wr & sof & (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + CNTW'(1);
    end
    if (accept & ~wr & (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNTW'(1);
    end
  end

  // Route FSM and saturating counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= WAIT_SOF;
      route_cur_q <= ROUTE_NONE;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      route_cur_q <= route_cur_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  axis_skid_buf #(.PW(PW)) u_buf (
    .aclk        (aclk),
    .areset      (areset),
    .in_valid_i  (wr),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (buf_out_valid),
    .out_ready_i (m_axis.tready),
    .out_data_o  (out_pl)
  );

  assign s_axis.tready = buf_in_ready;
  assign m_axis.tvalid = buf_out_valid;
  assign m_axis.tdata  = out_pl[DATAW-1:0];
  assign m_axis.tuser  = out_pl[DATAW];
  assign m_axis.tlast  = out_pl[DATAW+1];
  assign m_axis.tstrb  = out_pl[DATAW+2 +: KW];
  assign m_axis.tkeep  = out_pl[DATAW+2+KW +: KW];
  assign m_axis.tid    = out_pl[DATAW+2+2*KW];
  assign m_axis.tdest  = out_pl[DATAW+3+2*KW];
  assign out_tag       = out_pl[PW-1 -: 2];

  // Enables follow the head beat's tag; with nothing buffered they show the live route
  assign {m1_en, m0_en} = buf_out_valid ? out_tag : route_cur_q;

  assign route_cur  = route_cur_q;
  assign route_pend = (route_req != route_cur_q);
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign state_dbg  = (state_q == PASS);

endmodule
